// File: rtl/lcv_div_iter_if.sv
// Request/result handshake bundle for the iterative divider.
// The requester uses the master modport and the divider uses the slave modport.
interface lcv_div_iter_if #(
    parameter int WIDTH = 32
);
    logic             inp_valid;
    logic             inp_ready;
    logic [WIDTH-1:0] inp_a;
    logic [WIDTH-1:0] inp_b;
    logic             inp_signed;
    logic             outp_valid;
    logic             outp_ready;
    logic [WIDTH-1:0] outp_quot;
    logic [WIDTH-1:0] outp_rem;
    logic             outp_div_by_zero;

    modport master (
        output inp_valid, inp_a, inp_b, inp_signed, outp_ready,
        input  inp_ready, outp_valid, outp_quot, outp_rem, outp_div_by_zero
    );

    modport slave (
        input  inp_valid, inp_a, inp_b, inp_signed, outp_ready,
        output inp_ready, outp_valid, outp_quot, outp_rem, outp_div_by_zero
    );
endinterface

// File: rtl/lcv_div_iter.sv
// Radix-2 restoring divider: one quotient bit per cycle, fixed latency for every
// operand pair, including the divide-by-zero and signed-overflow cases.
module lcv_div_iter #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    lcv_div_iter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sgn_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    cnt_reg;
    logic             qneg_reg;
    logic             rneg_reg;
    logic             dz_reg;
    logic             ovf_reg;
    logic             ready_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             dbz_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;

    // Negating the most-negative value yields its own bit pattern, which is the
    // correct unsigned magnitude.
    assign a_mag   = (sgn_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign b_mag   = (sgn_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    assign r_shift = {r_reg, q_reg[WIDTH-1]};
    assign trial   = r_shift - {1'b0, b_reg};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sgn_reg   <= 1'b0;
            r_reg     <= '0;
            q_reg     <= '0;
            cnt_reg   <= '0;
            qneg_reg  <= 1'b0;
            rneg_reg  <= 1'b0;
            dz_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.inp_valid) begin
                        a_reg     <= bus.inp_a;
                        b_reg     <= bus.inp_b;
                        sgn_reg   <= bus.inp_signed;
                        ready_reg <= 1'b0;
                        state_reg <= PREP;
                    end
                end
                PREP: begin
                    // a_reg keeps the original dividend for the divide-by-zero remainder.
                    qneg_reg  <= sgn_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    rneg_reg  <= sgn_reg & a_reg[WIDTH-1];
                    dz_reg    <= (b_reg == '0);
                    ovf_reg   <= sgn_reg && (a_reg == MIN_VAL) && (b_reg == '1);
                    q_reg     <= a_mag;
                    b_reg     <= b_mag;
                    r_reg     <= '0;
                    cnt_reg   <= '0;
                    state_reg <= CALC;
                end
                CALC: begin
                    r_reg   <= trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
                    q_reg   <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    if (dz_reg) begin
                        quot_reg <= '1;
                        rem_reg  <= a_reg;
                        dbz_reg  <= 1'b1;
                    end else if (ovf_reg) begin
                        quot_reg <= MIN_VAL;
                        rem_reg  <= '0;
                        dbz_reg  <= 1'b0;
                    end else begin
                        quot_reg <= qneg_reg ? -q_reg : q_reg;
                        rem_reg  <= rneg_reg ? -r_reg : r_reg;
                        dbz_reg  <= 1'b0;
                    end
                    valid_reg <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    if (bus.outp_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Ready is held low for as long as reset is asserted.
    assign bus.inp_ready        = ready_reg & rst;
    assign bus.outp_valid       = valid_reg;
    assign bus.outp_quot        = quot_reg;
    assign bus.outp_rem         = rem_reg;
    assign bus.outp_div_by_zero = dbz_reg;
endmodule

// File: tb/tb_lcv_div_iter.sv
// Scoreboard bench for lcv_div_iter: a reference model fills the expected queue
// as requests are driven; results are popped and compared as the divider returns them.
module tb_lcv_div_iter;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    lcv_div_iter_if #(.WIDTH(W)) bus();

    lcv_div_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        if (b == '0) begin
            e.quot = '1;
            e.rem  = a;
            e.dbz  = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.quot = 32'h8000_0000;
            e.rem  = '0;
            e.dbz  = 1'b0;
        end else if (s) begin
            e.quot = $signed(a) / $signed(b);
            e.rem  = $signed(a) % $signed(b);
            e.dbz  = 1'b0;
        end else begin
            e.quot = a / b;
            e.rem  = a % b;
            e.dbz  = 1'b0;
        end
        return e;
    endfunction

    // Called at a falling edge. With bp>0 the result is held back for bp cycles
    // while the next request (qa/qb/qs) is already presented on the input side.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int bp, input logic [W-1:0] qa, input logic [W-1:0] qb,
                          input logic qs);
        exp_t e;
        int   lat;
        bit   ok;
        logic [W-1:0] cap_q, cap_r;
        logic cap_z;
        sb.push_back(model(a, b, s));
        bus.inp_valid  = 1'b1;
        bus.inp_a      = a;
        bus.inp_b      = b;
        bus.inp_signed = s;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.inp_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.inp_valid  = 1'b0;
        bus.inp_a      = $urandom;
        bus.inp_b      = $urandom;
        bus.inp_signed = 1'($urandom);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (bus.outp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) chk("valid_timeout", 64'd0, 64'd1);
        else chk("latency", 64'(lat), 64'(W + 3));
        if (bp > 0) begin
            cap_q = bus.outp_quot;
            cap_r = bus.outp_rem;
            cap_z = bus.outp_div_by_zero;
            bus.inp_valid  = 1'b1;
            bus.inp_a      = qa;
            bus.inp_b      = qb;
            bus.inp_signed = qs;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk("bp_quot", 64'(bus.outp_quot), 64'(cap_q));
                chk("bp_rem", {bus.outp_rem, 31'd0, bus.outp_div_by_zero}, {cap_r, 31'd0, cap_z});
                chk("bp_valid_ready", {bus.outp_valid, bus.inp_ready}, 64'b10);
            end
        end
        bus.outp_ready = 1'b1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("quot", 64'(bus.outp_quot), 64'(e.quot));
            chk("rem", 64'(bus.outp_rem), 64'(e.rem));
            chk("div_by_zero", 64'(bus.outp_div_by_zero), 64'(e.dbz));
        end else begin
            chk("scoreboard_empty", 64'd0, 64'd1);
        end
        $display("op a=%h b=%h signed=%0d -> quot=%h rem=%h dbz=%0d lat=%0d",
                 a, b, s, bus.outp_quot, bus.outp_rem, bus.outp_div_by_zero, lat);
        @(posedge clk);
        #1;
        bus.outp_ready = 1'b0;
        @(negedge clk);
        chk("post_handshake", {bus.outp_valid, bus.inp_ready}, 64'b01);
    endtask

    initial begin
        int seen;
        bus.inp_valid  = 1'b0;
        bus.inp_a      = '0;
        bus.inp_b      = '0;
        bus.inp_signed = 1'b0;
        bus.outp_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.outp_quot, bus.outp_rem}, 64'd0);
        chk("reset_ctrl", {bus.outp_valid, bus.inp_ready, bus.outp_div_by_zero}, 64'b000);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(bus.inp_ready), 64'd1);

        run_op(32'd100, 32'd7, 1'b0, 0, '0, '0, 1'b0);
        run_op(-32'sd7, 32'd2, 1'b1, 0, '0, '0, 1'b0);
        run_op(32'd7, -32'sd2, 1'b1, 0, '0, '0, 1'b0);
        run_op(-32'sd7, -32'sd2, 1'b1, 0, '0, '0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd2, 1'b0, 0, '0, '0, 1'b0);
        run_op(32'd5, 32'd0, 1'b0, 0, '0, '0, 1'b0);
        run_op(32'd5, 32'd0, 1'b1, 0, '0, '0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, '0, '0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, '0, '0, 1'b0);
        run_op(32'h8000_0000, 32'd3, 1'b1, 0, '0, '0, 1'b0);

        // Backpressure with a second request queued behind it.
        run_op(32'd1000, 32'd33, 1'b0, 10, -32'sd1000, 32'd33, 1'b1);
        run_op(-32'sd1000, 32'd33, 1'b1, 0, '0, '0, 1'b0);

        // Mid-operation reset: the aborted request must never produce a result.
        bus.inp_valid = 1'b1;
        bus.inp_a     = 32'd50;
        bus.inp_b     = 32'd5;
        bus.inp_signed = 1'b0;
        @(posedge clk);
        #1;
        bus.inp_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", {bus.outp_quot, bus.outp_rem}, 64'd0);
        chk("midreset_ctrl", {bus.outp_valid, bus.inp_ready, bus.outp_div_by_zero}, 64'b000);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_ready", 64'(bus.inp_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.outp_valid) seen++;
        end
        chk("no_stale_result", 64'(seen), 64'd0);
        run_op(32'd9, 32'd3, 1'b0, 0, '0, '0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            rs = 1'($urandom);
            if (k % 5 == 0) rb = rb >> $urandom_range(0, 31);
            run_op(ra, rb, rs, 0, '0, '0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lcv_div_iter.md
# lcv_div_iter

Iterative radix-2 integer divider with valid/ready handshakes. It is the inverse-direction companion to the team's multiply-accumulate blocks: where those produce `a*b + c`, this block produces quotient and remainder of `a / b`. It produces one quotient bit per cycle, trading latency for area. It sits beside the MAC/adder blocks in the ALU datapath and serves divide/remainder instructions.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width in bits; must be at least 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-low: `rst==0` at a rising edge resets the block.
- `inp_valid`  in  1  request valid.
- `inp_ready`  out  1  block can accept a request.
- `inp_a`  in  WIDTH  dividend.
- `inp_b`  in  WIDTH  divisor.
- `inp_signed`  in  1  1 = two's-complement operands, 0 = unsigned.
- `outp_valid`  out  1  result valid.
- `outp_ready`  in  1  consumer accepts the result.
- `outp_quot`  out  WIDTH  quotient.
- `outp_rem`  out  WIDTH  remainder.
- `outp_div_by_zero`  out  1  set when `inp_b` was 0.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- **IDLE**
  - `inp_ready=1`.
  - A handshake (`inp_valid & inp_ready`) latches `a`, `b` and `signed`, then moves to PREP.
- **PREP**
  - Records the result signs: quotient negative = `signed & (a[MSB]^b[MSB])`; remainder negative = `signed & a[MSB]`.
  - Replaces a and b with their magnitudes when signed.
  - Clears the partial remainder and the bit counter.
  - Flags two special cases: divide-by-zero (`b==0`) and signed overflow (`signed`, `a==1<<(WIDTH-1)`, `b==all-ones`).
  - Moves to CALC.
- **CALC**: WIDTH cycles of restoring division, MSB first.
  - Shift: `{r,q} <= {r,q}<<1`, taking in the next dividend bit.
  - Trial subtract: compute `r-|b|` at WIDTH+1 bits. If it is non-negative, store it in r and set the quotient bit.
  - After the counter reaches WIDTH-1, moves to FIX.
  - Special cases still spend all WIDTH cycles, so latency is fixed.
- **FIX**: loads the output registers.
  - Divide-by-zero: quot = all-ones, rem = original `a`, `outp_div_by_zero=1`.
  - Overflow: quot = `1<<(WIDTH-1)`, rem = 0.
  - Otherwise: apply two's-complement negation per the recorded signs. The remainder takes the sign of the dividend; the quotient truncates toward zero.
  - Moves to DONE.
- **DONE**
  - `outp_valid=1`.
  - On `outp_ready`, moves to IDLE.
  - No new request is accepted in the same cycle.
- Arithmetic
  - Internal remainder is WIDTH+1 bits.
  - Magnitude of the most-negative value is its unsigned bit pattern, with no overflow.
  - All outputs are registered.

## Timing
- Reset (`rst==0` at an edge):
  - State goes to IDLE.
  - `outp_valid=0`, `outp_quot=0`, `outp_rem=0`, `outp_div_by_zero=0`.
  - `inp_ready` is forced to 0 while `rst==0`, and is 1 on the first cycle after release.
- Latency: request accepted at edge T → `outp_valid` rises in cycle T+WIDTH+3, for every input including special cases.
  - PREP: 1 cycle.
  - CALC: WIDTH cycles.
  - FIX: 1 cycle.
- Throughput: at most one request per WIDTH+4 cycles, since DONE→IDLE costs one cycle.
- `inp_ready` is 0 in every state other than IDLE.
- Input ports are don't-care after the handshake.
- While `outp_valid & !outp_ready`, all `outp_*` hold stable. `outp_valid` never drops without a handshake.
- Output handshake edge: `outp_valid` is 0 the next cycle and `inp_ready` is 1 the next cycle.
- Reset mid-operation in any state:
  - Aborts immediately; no result is ever presented.
  - Behaviour afterwards is identical to power-on reset.
- `inp_valid` asserted in a non-IDLE state is ignored. The requester must hold it until `inp_ready`.

## Test plan
- Unsigned basic, WIDTH=32: `a=100, b=7, signed=0` → `quot=14, rem=2, div_by_zero=0`; `outp_valid` rises exactly 35 cycles after the accepting edge.
- Signed sign rules: `-7/2` → `quot=-3 (0xFFFFFFFD), rem=-1`; `7/-2` → `quot=-3, rem=1`; `-7/-2` → `quot=3, rem=-1`. Unsigned `0xFFFFFFFF/2` → `quot=0x7FFFFFFF, rem=1`.
- Divide-by-zero: `a=5, b=0`, both signed=0 and signed=1 → `quot=0xFFFFFFFF, rem=5, div_by_zero=1`, latency still 35.
- Signed overflow: `a=0x80000000, b=0xFFFFFFFF, signed=1` → `quot=0x80000000, rem=0, div_by_zero=0`. The same operands with signed=0 → `quot=0, rem=0x80000000`.
- Backpressure: hold `outp_ready=0` for 10 cycles after `outp_valid` → outputs constant and `inp_ready=0` throughout. Raise `outp_ready` → next cycle `outp_valid=0`, `inp_ready=1`. A queued second request returns the correct result.
- Mid-operation reset: drive `rst=0` for 1 cycle during CALC (cycle T+10) → next cycle `outp_valid=0`, all outputs 0. `inp_ready=1` after release. No stale result appears. A new request `a=9, b=3` → `quot=3, rem=0`.
